// File: rtl/icache_2way.sv
// 2-way set-associative instruction cache, one 32-bit word per line.
// Combinational lookup, same-cycle write bypass, per-set round-robin victim, flush.
module icache_2way #(
   parameter int ADDR_W  = 32,
   parameter int INDEX_W = 6,
   parameter int TAG_W   = ADDR_W - INDEX_W - 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic              hit_o,
   output logic [31:0]       inst_o,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [31:0]       winst_i
);
   localparam int SETS = 1 << INDEX_W;

   logic [SETS-1:0]  r_valid0, r_valid1, r_victim;
   logic [TAG_W-1:0] r_tag0  [SETS];
   logic [TAG_W-1:0] r_tag1  [SETS];
   logic [31:0]      r_data0 [SETS];
   logic [31:0]      r_data1 [SETS];

   logic [INDEX_W-1:0] w_ridx, w_widx;
   logic [TAG_W-1:0]   w_rtag, w_wtag;
   logic               w_hit0, w_hit1, w_bypass;
   logic               w_match0, w_match1, w_fill, w_way, w_victim_nxt;
   logic               w_unused;

   assign w_unused = ^{raddr_i[1:0], waddr_i[1:0]};

   assign w_ridx = raddr_i[INDEX_W+1:2];
   assign w_rtag = raddr_i[ADDR_W-1:INDEX_W+2];
   assign w_widx = waddr_i[INDEX_W+1:2];
   assign w_wtag = waddr_i[ADDR_W-1:INDEX_W+2];

   assign w_hit0   = r_valid0[w_ridx] && (r_tag0[w_ridx] == w_rtag);
   assign w_hit1   = r_valid1[w_ridx] && (r_tag1[w_ridx] == w_rtag);
   assign w_bypass = we_i && (waddr_i[ADDR_W-1:2] == raddr_i[ADDR_W-1:2]);

   always_comb begin
      hit_o  = 1'b0;
      inst_o = 32'h0;
      if (!rst && !flush_i) begin
         if (w_bypass) begin
            hit_o  = 1'b1;
            inst_o = winst_i;
         end else if (w_hit0) begin
            hit_o  = 1'b1;
            inst_o = r_data0[w_ridx];
         end else if (w_hit1) begin
            hit_o  = 1'b1;
            inst_o = r_data1[w_ridx];
         end
      end
   end

   assign w_match0 = r_valid0[w_widx] && (r_tag0[w_widx] == w_wtag);
   assign w_match1 = r_valid1[w_widx] && (r_tag1[w_widx] == w_wtag);
   assign w_fill   = we_i && !flush_i && !rst;

   // Way selection: refresh a matching line in place so a tag never lives in both ways
   always_comb begin
      w_way        = 1'b0;
      w_victim_nxt = r_victim[w_widx];
      if (w_match0) begin
         w_way = 1'b0;
      end else if (w_match1) begin
         w_way = 1'b1;
      end else if (!r_valid0[w_widx]) begin
         w_way        = 1'b0;
         w_victim_nxt = 1'b1;
      end else if (!r_valid1[w_widx]) begin
         w_way        = 1'b1;
         w_victim_nxt = 1'b0;
      end else begin
         w_way        = r_victim[w_widx];
         w_victim_nxt = ~r_victim[w_widx];
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         r_valid0 <= '0;
         r_valid1 <= '0;
         r_victim <= '0;
      end else if (we_i) begin
         r_victim[w_widx] <= w_victim_nxt;
         if (w_way) r_valid1[w_widx] <= 1'b1;
         else       r_valid0[w_widx] <= 1'b1;
      end
   end

   // Tag/data arrays carry no reset; valid bits gate their use
   always_ff @(posedge clk) begin
      if (w_fill) begin
         if (w_way) begin
            r_tag1[w_widx]  <= w_wtag;
            r_data1[w_widx] <= winst_i;
         end else begin
            r_tag0[w_widx]  <= w_wtag;
            r_data0[w_widx] <= winst_i;
         end
      end
   end
endmodule

// File: tb/tb_icache_2way.sv
// Directed self-checking bench for icache_2way (INDEX_W=6, set 0 = 0x000/0x100/0x200/0x300).
module tb_icache_2way;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush_i = 1'b0;
   logic [31:0] raddr_i = '0;
   logic        hit_o;
   logic [31:0] inst_o;
   logic        we_i = 1'b0;
   logic [31:0] waddr_i = '0;
   logic [31:0] winst_i = '0;
   int checks = 0;
   int errors = 0;

   icache_2way #(.ADDR_W(32), .INDEX_W(6)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .raddr_i(raddr_i),
      .hit_o(hit_o), .inst_o(inst_o), .we_i(we_i), .waddr_i(waddr_i), .winst_i(winst_i)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: timeout reached, required finish before 100000");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic fill(input logic [31:0] a, input logic [31:0] d);
      we_i = 1'b1; waddr_i = a; winst_i = d;
      step();
      we_i = 1'b0;
   endtask

   task automatic look(input logic [31:0] a);
      raddr_i = a;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; step(); step(); rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; step();
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL reset_during: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      step(); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         look(32'h100 + 32'(i * 4)); checks++;
         if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
            errors++; $display("FAIL reset_miss[%0d]: hit=%b inst=%h, required 0/0", i, hit_o, inst_o);
         end
      end
   endtask

   task automatic test_fill_hit();
      fill(32'h100, 32'h0000_0013);
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h0000_0013}) begin
         errors++; $display("FAIL fill_hit: hit=%b inst=%h, required 1/00000013", hit_o, inst_o);
      end
   endtask

   task automatic test_bypass();
      we_i = 1'b1; waddr_i = 32'h200; winst_i = 32'hDEAD_BEEF;
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL bypass_hit: hit=%b inst=%h, required 1/deadbeef", hit_o, inst_o);
      end
      look(32'h204); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL bypass_other: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      step(); we_i = 1'b0;
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'hDEAD_BEEF}) begin
         errors++; $display("FAIL bypass_stored: hit=%b inst=%h, required 1/deadbeef", hit_o, inst_o);
      end
   endtask

   // After reset: 0x000->w0, 0x100->w1, 0x200 evicts w0 (victim then 1)
   task automatic test_replace();
      do_reset();
      fill(32'h000, 32'h1111_0000);
      fill(32'h100, 32'h1111_0100);
      fill(32'h200, 32'h1111_0200);
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h1111_0100}) begin
         errors++; $display("FAIL repl_100: hit=%b inst=%h, required 1/11110100", hit_o, inst_o);
      end
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h1111_0200}) begin
         errors++; $display("FAIL repl_200: hit=%b inst=%h, required 1/11110200", hit_o, inst_o);
      end
      look(32'h000); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL repl_000_evicted: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
   endtask

   // Refill keeps victim=1, so the later 0x300 fill must take way1 (0x100)
   task automatic test_refill();
      fill(32'h100, 32'hAAAA_5555);
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'hAAAA_5555}) begin
         errors++; $display("FAIL refill_data: hit=%b inst=%h, required 1/aaaa5555", hit_o, inst_o);
      end
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h1111_0200}) begin
         errors++; $display("FAIL refill_other: hit=%b inst=%h, required 1/11110200", hit_o, inst_o);
      end
      fill(32'h300, 32'h1111_0300);
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL fourth_evicts_100: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h1111_0200}) begin
         errors++; $display("FAIL fourth_keeps_200: hit=%b inst=%h, required 1/11110200", hit_o, inst_o);
      end
      look(32'h300); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h1111_0300}) begin
         errors++; $display("FAIL fourth_300: hit=%b inst=%h, required 1/11110300", hit_o, inst_o);
      end
   endtask

   task automatic test_flush();
      flush_i = 1'b1; we_i = 1'b1; waddr_i = 32'h400; winst_i = 32'h4444_4444;
      look(32'h400); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL flush_no_bypass: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      step(); flush_i = 1'b0; we_i = 1'b0;
      look(32'h400); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL flush_drop_400: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      look(32'h200); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL flush_200: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      look(32'h300); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL flush_300: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
   endtask

   task automatic test_mid_reset();
      fill(32'h100, 32'h0BAD_F00D);
      fill(32'h204, 32'h0000_0204);
      look(32'h204); checks++;
      if ({hit_o, inst_o} !== {1'b1, 32'h0000_0204}) begin
         errors++; $display("FAIL pre_rst_204: hit=%b inst=%h, required 1/00000204", hit_o, inst_o);
      end
      rst = 1'b1; we_i = 1'b1; waddr_i = 32'h300; winst_i = 32'h3333_3333;
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL rst_active: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      step(); rst = 1'b0; we_i = 1'b0;
      look(32'h100); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL rst_100: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      look(32'h204); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL rst_204: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
      look(32'h300); checks++;
      if ({hit_o, inst_o} !== {1'b0, 32'h0}) begin
         errors++; $display("FAIL rst_drop_300: hit=%b inst=%h, required 0/0", hit_o, inst_o);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill_hit();
      test_bypass();
      test_replace();
      test_refill();
      test_flush();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
